// File: rtl/xsim_msg_source_arb.sv
// rtl/xsim_msg_source_arb.sv - per-channel beat FIFOs, round-robin grant, 32-bit word serialiser
module xsim_msg_source_arb #(
    parameter int NUM_CH      = 4,
    parameter int BEAT_WIDTH  = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int PORTAL_BASE = 0,
    parameter int USE_DPI     = 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_CH-1:0]            enq_valid,
    input  logic [NUM_CH*BEAT_WIDTH-1:0] enq_beat,
    output logic [NUM_CH-1:0]            enq_ready,
    output logic                         out_valid,
    output logic [31:0]                  out_portal,
    output logic [31:0]                  out_word,
    output logic                         out_last,
    output logic [NUM_CH-1:0]            overflow
);

    localparam int WORDS = BEAT_WIDTH / 32;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;

    logic [BEAT_WIDTH-1:0] mem [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_CH];
    logic [PW-1:0]         rd_ptr [NUM_CH];
    logic [CW-1:0]         count  [NUM_CH];
    logic [NUM_CH-1:0]     push, pop, nonempty;
    logic [CHW-1:0]        rr_q, grant;
    logic                  load, shift;
    logic [BEAT_WIDTH-1:0] shift_q, head;
    logic [IW-1:0]         idx_q;

    function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CHW'(s);
    endfunction

    // Ready comes from the registered count only, so a full FIFO stays not-ready even when popped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            enq_ready[i] = (count[i] != FULL_CNT);
            nonempty[i]  = (count[i] != '0);
            push[i]      = enq_valid[i] && enq_ready[i];
            pop[i]       = load && (grant == CHW'(i));
        end
    end

    // Round-robin search from rr_q; lowest offset wins, hence the descending scan.
    always_comb begin
        grant = rr_q;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (nonempty[wrap_add(rr_q, k)]) grant = wrap_add(rr_q, k);
        end
    end

    assign head      = mem[grant][rd_ptr[grant]];
    assign out_valid = (state_q == BUSY);

    // Serialiser state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a new grant is taken on the edge the last word leaves, giving no bubbles.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|nonempty) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (out_last) begin
                    if (|nonempty) load    = 1'b1;
                    else           state_d = IDLE;
                end else begin
                    shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output word registers, shift register, word index and round-robin pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_q    <= '0;
            idx_q      <= '0;
            out_portal <= '0;
            out_word   <= '0;
            out_last   <= 1'b0;
            rr_q       <= '0;
        end else if (load) begin
            shift_q    <= head >> 32;
            out_word   <= head[31:0];
            out_portal <= 32'(PORTAL_BASE) + 32'(grant);
            idx_q      <= '0;
            out_last   <= (WORDS == 1);
            rr_q       <= wrap_add(grant, 1);
        end else if (shift) begin
            shift_q  <= shift_q >> 32;
            out_word <= shift_q[31:0];
            idx_q    <= idx_q + IW'(1);
            out_last <= ((idx_q + IW'(1)) == LAST_IDX);
        end else begin
            out_last <= 1'b0;
        end
    end

    // FIFO pointers, occupancy counts and sticky overflow flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                count[i]    <= count[i] + CW'(push[i]) - CW'(pop[i]);
                overflow[i] <= overflow[i] | (enq_valid[i] & ~enq_ready[i]);
            end
        end
    end

    // FIFO storage; contents need no reset because counts gate every read.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= enq_beat[i*BEAT_WIDTH +: BEAT_WIDTH];
        end
    end

endmodule
